adder: RTL and testbench

ADDER -- requirements
Module: adder

---
 rtl/adder.sv | 129 ++++++++++++
 tb/tb_adder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/adder.sv
// Saturating two's-complement adder/subtractor with a one-cycle registered result.
// The raw sum comes from 4-bit carry-lookahead slices whose group generate and
// propagate terms feed a second-level lookahead unit, so no carry ripples
// through all of the bits in series.

// 4-bit carry-lookahead slice: local sum plus group generate/propagate.
module adder_cla4 (
    input  logic       cin,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] sum,
    output logic       gg,
    output logic       pg
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every internal carry is a flat function of g, p and cin, never of a neighbouring carry.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;

    // Group terms are independent of cin, so the upper lookahead level has no loop through the slices.
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
    assign pg = &p;

endmodule

module adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic [WIDTH-1:0] Sum,
    output logic             Ovfl
);

    localparam int NS = WIDTH / 4;

    localparam logic [WIDTH-1:0] MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAXNEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Carry into slice idx+1, written out as a flat OR of products over the
    // lower slices' group generate and propagate terms and the carry-in.
    function automatic logic lookahead(input logic [NS-1:0] g,
                                       input logic [NS-1:0] p,
                                       input logic          cin,
                                       input int            idx);
        logic c;
        logic pp;
        c  = 1'b0;
        pp = 1'b1;
        for (int k = idx; k >= 0; k--) begin
            c  = c | (pp & g[k]);
            pp = pp & p[k];
        end
        c = c | (pp & cin);
        return c;
    endfunction

    logic [WIDTH-1:0] beff;
    logic [WIDTH-1:0] raw;
    logic [NS-1:0]    sg;
    logic [NS-1:0]    sp;
    logic [NS-1:0]    sc;
    logic             posovf;
    logic             negovf;
    logic [WIDTH-1:0] result;

    // Subtraction reuses the adder: invert B here, and Sub becomes the carry-in below.
    assign beff = Sub ? ~B : B;

    for (genvar s = 0; s < NS; s++) begin : g_slice
        adder_cla4 u_cla4 (
            .cin (sc[s]),
            .a   (A[4*s+3:4*s]),
            .b   (beff[4*s+3:4*s]),
            .sum (raw[4*s+3:4*s]),
            .gg  (sg[s]),
            .pg  (sp[s])
        );
    end

    // Second-level lookahead: forms every slice carry-in from the group terms and Sub.
    always_comb begin
        sc    = '0;
        sc[0] = Sub;
        for (int s = 1; s < NS; s++) begin
            sc[s] = lookahead(sg, sp, Sub, s - 1);
        end
    end

    // Overflow is judged on sign bits only; the carry out of the top bit is never formed.
    always_comb begin
        posovf = ~A[WIDTH-1] & ~beff[WIDTH-1] &  raw[WIDTH-1];
        negovf =  A[WIDTH-1] &  beff[WIDTH-1] & ~raw[WIDTH-1];
        result = raw;
        if (posovf) begin
            result = MAXPOS;
        end else if (negovf) begin
            result = MAXNEG;
        end
    end

    // Result register: cleared asynchronously, reloaded on every rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum  <= '0;
            Ovfl <= 1'b0;
        end else begin
            Sum  <= result;
            Ovfl <= posovf | negovf;
        end
    end

endmodule

// File: tb/tb_adder.sv
// Directed testbench for the saturating adder/subtractor.
module tb_adder;

    logic        clk;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic        Sub;
    logic [15:0] Sum;
    logic        Ovfl;

    int vectors;
    int miscompares;

    adder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Sub   (Sub),
        .Sum   (Sum),
        .Ovfl  (Ovfl)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive operands on the falling edge, then sample just after the next rising edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic sub);
        @(negedge clk);
        A   = a;
        B   = b;
        Sub = sub;
        @(posedge clk);
        #1;
    endtask

    // Compare both outputs against hand-computed values.
    task automatic checkOutput(input string tag, input logic [15:0] expSum, input logic expOvfl);
        vectors++;
        assert (Sum === expSum) else begin
            miscompares++;
            $error("[TB] FAIL %s Sum: observed %h expected %h", tag, Sum, expSum);
        end
        vectors++;
        assert (Ovfl === expOvfl) else begin
            miscompares++;
            $error("[TB] FAIL %s Ovfl: observed %b expected %b", tag, Ovfl, expOvfl);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        A           = 16'h7FFF;
        B           = 16'h0001;
        Sub         = 1'b0;

        // Outputs stay clear while reset is held, even with edges and overflowing inputs.
        #2;
        checkOutput("reset_initial", 16'h0000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_held", 16'h0000, 1'b0);

        // Release reset on a falling edge; the first rising edge loads the current inputs.
        @(negedge clk);
        A     = 16'h1234;
        B     = 16'h4321;
        Sub   = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("first_after_reset", 16'h5555, 1'b0);

        // Outputs hold between edges while the inputs move.
        @(negedge clk);
        A = 16'h7FFF;
        B = 16'h7FFF;
        #2;
        checkOutput("hold_between_edges", 16'h5555, 1'b0);

        applyStimulus(16'h1234, 16'h0212, 1'b1);
        checkOutput("sub_basic", 16'h1022, 1'b0);

        applyStimulus(16'h7FFF, 16'h0001, 1'b0);
        checkOutput("pos_sat_add", 16'h7FFF, 1'b1);

        applyStimulus(16'h0000, 16'h8000, 1'b1);
        checkOutput("zero_minus_8000", 16'h7FFF, 1'b1);

        applyStimulus(16'h8000, 16'h8001, 1'b0);
        checkOutput("neg_sat_add", 16'h8000, 1'b1);

        applyStimulus(16'h8000, 16'h0001, 1'b1);
        checkOutput("neg_sat_sub", 16'h8000, 1'b1);

        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        checkOutput("unsigned_wrap", 16'h0000, 1'b0);

        applyStimulus(16'h0005, 16'h0007, 1'b1);
        checkOutput("sub_negative", 16'hFFFE, 1'b0);

        applyStimulus(16'h8000, 16'h8000, 1'b1);
        checkOutput("min_minus_min", 16'h0000, 1'b0);

        applyStimulus(16'h7FFF, 16'hFFFF, 1'b1);
        checkOutput("max_minus_neg1", 16'h7FFF, 1'b1);

        applyStimulus(16'h4000, 16'h4000, 1'b0);
        checkOutput("pos_sat_midrange", 16'h7FFF, 1'b1);

        applyStimulus(16'hC000, 16'hC000, 1'b0);
        checkOutput("exact_min_no_ovfl", 16'h8000, 1'b0);

        applyStimulus(16'h0FFF, 16'h0001, 1'b0);
        checkOutput("carry_three_slices", 16'h1000, 1'b0);

        applyStimulus(16'h00FF, 16'h0F01, 1'b0);
        checkOutput("carry_slice_chain", 16'h1000, 1'b0);

        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
        checkOutput("sub_full_propagate", 16'h0000, 1'b0);

        applyStimulus(16'h0001, 16'h7FFF, 1'b0);
        checkOutput("pos_sat_swapped", 16'h7FFF, 1'b1);

        // Mid-cycle reset clears an overflowing result before the next edge.
        applyStimulus(16'h7FFF, 16'h0001, 1'b0);
        checkOutput("pre_async_reset", 16'h7FFF, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_clear", 16'h0000, 1'b0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reload_after_reset", 16'h7FFF, 1'b1);

        applyStimulus(16'h2222, 16'h1111, 1'b1);
        checkOutput("sub_after_reset", 16'h1111, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
